// File: rtl/imem_loader.sv
// Instruction memory loader: unpacks a length/data/checksum byte frame from a host
// link into 32-bit words written sequentially from BASE_ADDR, holding the CPU meanwhile.
module imem_loader #(
    parameter int ADDR_W    = 14,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              cpu_hold,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded
);

    // Handshake: a byte moves only in a cycle where byte_valid & byte_ready are both
    // high; byte_ready is decoded from state alone, never from byte_valid.
    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_WRITE,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [31:0]     ROOM  = 32'((1 << ADDR_W) - BASE_ADDR);
    localparam logic [ADDR_W:0] ONE_W = 1;

    state_t            state, state_n;
    logic [7:0]        len_lo_q;
    logic [ADDR_W:0]   len_q;
    logic [ADDR_W-1:0] addr_q;
    logic [23:0]       word_q;
    logic [1:0]        idx_q;
    logic [7:0]        csum_q;

    logic              xfer;
    logic [15:0]       len16;
    logic              len_bad;
    logic              last_word;
    logic              start_ok;

    assign xfer      = byte_valid & byte_ready;
    assign len16     = {byte_data, len_lo_q};
    assign len_bad   = (len16 == 16'd0) || (32'(len16) > ROOM);
    assign last_word = ((words_loaded + ONE_W) == len_q);
    assign start_ok  = start && (state == S_IDLE || state == S_DONE || state == S_ERR);

    always_comb begin
        state_n    = state;
        byte_ready = 1'b0;
        cpu_hold   = 1'b0;
        done       = 1'b0;
        error      = 1'b0;
        wr_en      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_n = S_LEN_LO;
            end
            S_LEN_LO: begin
                byte_ready = 1'b1;
                cpu_hold   = 1'b1;
                if (xfer) state_n = S_LEN_HI;
            end
            S_LEN_HI: begin
                byte_ready = 1'b1;
                cpu_hold   = 1'b1;
                if (xfer) state_n = len_bad ? S_ERR : S_DATA;
            end
            S_DATA: begin
                byte_ready = 1'b1;
                cpu_hold   = 1'b1;
                if (xfer && idx_q == 2'd3) state_n = S_WRITE;
            end
            S_WRITE: begin
                cpu_hold = 1'b1;
                wr_en    = 1'b1;
                state_n  = last_word ? S_CSUM : S_DATA;
            end
            S_CSUM: begin
                byte_ready = 1'b1;
                cpu_hold   = 1'b1;
                if (xfer) state_n = (byte_data == csum_q) ? S_DONE : S_ERR;
            end
            S_DONE: begin
                done = 1'b1;
                if (start) state_n = S_LEN_LO;
            end
            S_ERR: begin
                error = 1'b1;
                if (start) state_n = S_LEN_LO;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            len_lo_q     <= '0;
            len_q        <= '0;
            addr_q       <= '0;
            word_q       <= '0;
            idx_q        <= '0;
            csum_q       <= '0;
            wr_addr      <= '0;
            wr_data      <= '0;
            words_loaded <= '0;
        end else begin
            state <= state_n;
            if (start_ok) words_loaded <= '0;
            case (state)
                S_LEN_LO: begin
                    if (xfer) len_lo_q <= byte_data;
                end
                S_LEN_HI: begin
                    if (xfer) begin
                        len_q  <= (ADDR_W+1)'(len16);
                        addr_q <= ADDR_W'(BASE_ADDR);
                        csum_q <= '0;
                        idx_q  <= '0;
                    end
                end
                S_DATA: begin
                    if (xfer) begin
                        csum_q <= csum_q ^ byte_data;
                        idx_q  <= idx_q + 2'd1;
                        // Output registers only change at the 4th byte so they hold between strobes.
                        if (idx_q == 2'd3) begin
                            wr_data <= {byte_data, word_q};
                            wr_addr <= addr_q;
                        end else begin
                            word_q[idx_q*8 +: 8] <= byte_data;
                        end
                    end
                end
                S_WRITE: begin
                    words_loaded <= words_loaded + ONE_W;
                    idx_q        <= '0;
                    if (!last_word) addr_q <= addr_q + ADDR_W'(1);
                end
                default: ;
            endcase
        end
    end

    a_no_back_to_back: assert property (@(posedge clk) disable iff (rst) wr_en |=> !wr_en);
    a_no_ready_in_write: assert property (@(posedge clk) disable iff (rst) wr_en |-> !byte_ready);

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: frames driven byte by byte, expected writes queued as
// {addr, data} and compared when the loader strobes wr_en.
module tb_imem_loader;

    localparam int ADDR_W  = 14;
    localparam int HI_BASE = 16380;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst, start_lo, start_hi, byte_valid;
    logic [7:0]        byte_data;
    logic              lo_ready, lo_wr_en, lo_hold, lo_done, lo_error;
    logic [ADDR_W-1:0] lo_wr_addr;
    logic [31:0]       lo_wr_data;
    logic [ADDR_W:0]   lo_words;
    logic              hi_ready, hi_wr_en, hi_hold, hi_done, hi_error;
    logic [ADDR_W-1:0] hi_wr_addr;
    logic [31:0]       hi_wr_data;
    logic [ADDR_W:0]   hi_words;

    imem_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(0)) u_dut (
        .clk(clk), .rst(rst), .start(start_lo), .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_ready(lo_ready), .wr_en(lo_wr_en), .wr_addr(lo_wr_addr), .wr_data(lo_wr_data),
        .cpu_hold(lo_hold), .done(lo_done), .error(lo_error), .words_loaded(lo_words)
    );

    imem_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(HI_BASE)) u_dut_hi (
        .clk(clk), .rst(rst), .start(start_hi), .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_ready(hi_ready), .wr_en(hi_wr_en), .wr_addr(hi_wr_addr), .wr_data(hi_wr_data),
        .cpu_hold(hi_hold), .done(hi_done), .error(hi_error), .words_loaded(hi_words)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    logic [45:0] exp_lo_q[$];
    logic [45:0] exp_hi_q[$];
    int          wr_cnt_lo = 0;
    int          wr_cnt_hi = 0;
    int          cyc = 0;
    int          last_xfer_cyc = -10;
    logic        prev_wr_lo = 1'b0;
    logic [31:0] frame_w[8];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Monitor for the BASE_ADDR=0 loader: write timing, ready/strobe relation, scoreboard.
    always @(posedge clk) begin
        if (!rst) begin
            if (lo_hold && !lo_ready) check("ready_low_only_in_write", lo_wr_en, 1);
            if (lo_wr_en) begin
                wr_cnt_lo++;
                check("wr_latency", cyc, last_xfer_cyc + 1);
                check("ready_in_write", lo_ready, 0);
                check("wr_back_to_back", prev_wr_lo, 0);
                check("lo_wr_expected", exp_lo_q.size() > 0, 1);
                if (exp_lo_q.size() > 0) check("lo_wr", {lo_wr_addr, lo_wr_data}, exp_lo_q.pop_front());
            end
            if (byte_valid && lo_ready) last_xfer_cyc = cyc;
        end
        prev_wr_lo = lo_wr_en;
        cyc++;
    end

    always @(posedge clk) begin
        if (!rst && hi_wr_en) begin
            wr_cnt_hi++;
            check("hi_wr_expected", exp_hi_q.size() > 0, 1);
            if (exp_hi_q.size() > 0) check("hi_wr", {hi_wr_addr, hi_wr_data}, exp_hi_q.pop_front());
        end
    end

    // All driver tasks start and end just after a falling edge.
    task automatic start_load(input bit sel);
        if (sel) start_hi = 1'b1; else start_lo = 1'b1;
        @(negedge clk);
        start_lo = 1'b0;
        start_hi = 1'b0;
    endtask

    task automatic send_byte(input bit sel, input logic [7:0] b, input bit gaps);
        int budget;
        if (gaps) begin
            repeat ($urandom_range(0, 3)) begin
                byte_valid = 1'b0;
                byte_data  = 8'($urandom);
                if (sel) start_hi = ($urandom_range(0, 2) == 0);
                else     start_lo = ($urandom_range(0, 2) == 0);
                @(negedge clk);
                start_lo = 1'b0;
                start_hi = 1'b0;
            end
        end
        byte_valid = 1'b1;
        byte_data  = b;
        budget     = 0;
        while (!(sel ? hi_ready : lo_ready) && budget < 40) begin
            @(negedge clk);
            budget++;
        end
        if (budget >= 40) check("ready_timeout", sel ? hi_ready : lo_ready, 1);
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic send_frame(input bit sel, input int n, input int base,
                              input logic [7:0] csum_flip, input bit gaps);
        logic [15:0] len;
        logic [7:0]  cs;
        logic [7:0]  b;
        logic [13:0] a;
        len = n[15:0];
        cs  = 8'h00;
        send_byte(sel, len[7:0], gaps);
        send_byte(sel, len[15:8], gaps);
        for (int i = 0; i < n; i++) begin
            a = 14'(base + i);
            if (sel) exp_hi_q.push_back({a, frame_w[i]});
            else     exp_lo_q.push_back({a, frame_w[i]});
            for (int k = 0; k < 4; k++) begin
                b  = frame_w[i][k*8 +: 8];
                cs = cs ^ b;
                send_byte(sel, b, gaps);
            end
        end
        send_byte(sel, cs ^ csum_flip, gaps);
    endtask

    task automatic wait_end(input bit sel);
        int budget;
        budget = 0;
        while (!(sel ? (hi_done | hi_error) : (lo_done | lo_error)) && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        if (budget >= 20) check("end_timeout", sel ? hi_done : lo_done, 1);
    endtask

    task automatic check_end(input bit sel, input logic exp_done, input logic exp_err, input int words);
        check("done", sel ? hi_done : lo_done, exp_done);
        check("error", sel ? hi_error : lo_error, exp_err);
        check("cpu_hold_released", sel ? hi_hold : lo_hold, 0);
        check("words_loaded", sel ? hi_words : lo_words, words);
    endtask

    initial begin
        int wc;
        rst        = 1'b1;
        start_lo   = 1'b0;
        start_hi   = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state
        check("rst_ready", lo_ready, 0);
        check("rst_wr_en", lo_wr_en, 0);
        check("rst_wr_addr", lo_wr_addr, 0);
        check("rst_wr_data", lo_wr_data, 0);
        check_end(0, 0, 0, 0);
        check_end(1, 0, 0, 0);

        // Two-word load with good checksum
        frame_w[0] = 32'h12345678;
        frame_w[1] = 32'hDEADBEEF;
        start_load(0);
        check("hold_during_load", lo_hold, 1);
        send_frame(0, 2, 0, 8'h00, 0);
        wait_end(0);
        check_end(0, 1, 0, 2);

        // Same frame, corrupted checksum: writes still land, then error
        wc = wr_cnt_lo;
        start_load(0);
        check("start_clears_done", lo_done, 0);
        send_frame(0, 2, 0, 8'hFF, 0);
        wait_end(0);
        check_end(0, 0, 1, 2);
        check("bad_csum_writes", wr_cnt_lo - wc, 2);

        // Zero length and over-depth length
        wc = wr_cnt_lo;
        start_load(0);
        send_byte(0, 8'h00, 0);
        send_byte(0, 8'h00, 0);
        check("len0_error_now", lo_error, 1);
        check_end(0, 0, 1, 0);
        start_load(0);
        send_byte(0, 8'h01, 0);
        send_byte(0, 8'h40, 0);
        check("len4001_error_now", lo_error, 1);
        check_end(0, 0, 1, 0);
        check("len_err_no_writes", wr_cnt_lo - wc, 0);

        // Three-word load with random gaps and stray start pulses
        for (int i = 0; i < 3; i++) frame_w[i] = $urandom;
        start_load(0);
        send_frame(0, 3, 0, 8'h00, 1);
        wait_end(0);
        check_end(0, 1, 0, 3);

        // Reset after 6 data bytes of a 2-word frame
        frame_w[0] = 32'hA5A55A5A;
        frame_w[1] = 32'h0F0F1234;
        wc = wr_cnt_lo;
        start_load(0);
        send_byte(0, 8'h02, 0);
        send_byte(0, 8'h00, 0);
        exp_lo_q.push_back({14'd0, frame_w[0]});
        for (int k = 0; k < 4; k++) send_byte(0, frame_w[0][k*8 +: 8], 0);
        send_byte(0, frame_w[1][7:0], 0);
        send_byte(0, frame_w[1][15:8], 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_one_write", wr_cnt_lo - wc, 1);
        check("midrst_ready", lo_ready, 0);
        check("midrst_wr_en", lo_wr_en, 0);
        check("midrst_wr_addr", lo_wr_addr, 0);
        check("midrst_wr_data", lo_wr_data, 0);
        check_end(0, 0, 0, 0);
        frame_w[0] = 32'hCAFEF00D;
        start_load(0);
        send_frame(0, 1, 0, 8'h00, 0);
        wait_end(0);
        check_end(0, 1, 0, 1);

        // Top-of-memory load at BASE_ADDR=16380
        for (int i = 0; i < 4; i++) frame_w[i] = $urandom;
        start_load(1);
        send_frame(1, 4, HI_BASE, 8'h00, 0);
        wait_end(1);
        check_end(1, 1, 0, 4);
        check("hi_writes", wr_cnt_hi, 4);
        start_load(1);
        send_byte(1, 8'h05, 0);
        send_byte(1, 8'h00, 0);
        check("hi_n5_error", hi_error, 1);
        check_end(1, 0, 1, 0);

        repeat (3) @(negedge clk);
        check("lo_queue_drained", exp_lo_q.size(), 0);
        check("hi_queue_drained", exp_hi_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
